// File: rtl/scan_chain_ctrl_if.sv
// Command, serial-scan and parallel capture/update signals of the scan
// chain controller, bundled for the test-access side (master) and the
// controller itself (slave).
interface scan_chain_ctrl_if #(
  parameter int NUM_SCAN_BITS = 395,
  parameter int NUM_LANES     = 1
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [NUM_LANES-1:0]     scan_in;
  logic                     scan_in_valid;
  logic [NUM_LANES-1:0]     scan_out;
  logic                     busy;
  logic [NUM_SCAN_BITS-1:0] par_in;
  logic [NUM_SCAN_BITS-1:0] scan_reg;
  logic                     update_pulse;
  logic                     done;

  modport master (
    output cmd_valid, cmd_op, scan_in, scan_in_valid, par_in,
    input  cmd_ready, scan_out, busy, scan_reg, update_pulse, done
  );

  modport slave (
    input  cmd_valid, cmd_op, scan_in, scan_in_valid, par_in,
    output cmd_ready, scan_out, busy, scan_reg, update_pulse, done
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Single-clock scan chain controller. A command FSM sequences an optional
// parallel capture into the shift register, a stall-tolerant shift of
// NUM_LANES bits per step, and an optional transfer of the shift register
// into the shadow register (scan_reg) that configures the core.
module scan_chain_ctrl #(
  parameter int                       NUM_SCAN_BITS = 395,
  parameter int                       NUM_LANES     = 1,
  parameter logic [NUM_SCAN_BITS-1:0] SCAN_RESET    = {NUM_SCAN_BITS{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  scan_chain_ctrl_if.slave  bus
);

  localparam int SHIFT_CYCLES = NUM_SCAN_BITS / NUM_LANES;
  localparam int CW           = $clog2(SHIFT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SHIFT_CYCLES - 1);

  localparam logic [1:0] OP_SHIFT      = 2'b00;
  localparam logic [1:0] OP_CAP_SHIFT  = 2'b01;
  localparam logic [1:0] OP_UPDATE     = 2'b10;
  localparam logic [1:0] OP_CAP_SH_UPD = 2'b11;

  if (NUM_SCAN_BITS % NUM_LANES != 0) begin : g_len_check
    $error("scan_chain_ctrl: NUM_SCAN_BITS must be a multiple of NUM_LANES");
  end

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE
  } state_t;

  state_t                   state;
  logic [1:0]               op_q;
  logic [CW-1:0]            cnt;
  logic [NUM_SCAN_BITS-1:0] sr;
  logic [NUM_SCAN_BITS-1:0] scan_reg_q;
  logic                     done_q;
  logic                     update_pulse_q;

  // New lanes enter at the LSB end, so the first lanes shifted in travel
  // up to the MSBs by the time the whole chain word has been loaded.
  logic [NUM_SCAN_BITS+NUM_LANES-1:0] sr_cat;
  logic [NUM_SCAN_BITS-1:0]           sr_shifted;
  assign sr_cat     = {sr, bus.scan_in};
  assign sr_shifted = sr_cat[NUM_SCAN_BITS-1:0];

  // Command FSM with shift register, shadow register and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= OP_SHIFT;
      cnt            <= '0;
      sr             <= '0;
      scan_reg_q     <= SCAN_RESET;
      done_q         <= 1'b0;
      update_pulse_q <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      update_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q <= bus.cmd_op;
            cnt  <= '0;
            case (bus.cmd_op)
              OP_CAP_SHIFT, OP_CAP_SH_UPD: state <= CAPTURE;
              OP_UPDATE:                   state <= UPDATE;
              default:                     state <= SHIFT;
            endcase
          end
        end
        CAPTURE: begin
          sr    <= bus.par_in;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          // A low scan_in_valid freezes both sr and cnt for as long as the
          // serial source stalls.
          if (bus.scan_in_valid) begin
            sr  <= sr_shifted;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              if (op_q == OP_CAP_SH_UPD) begin
                state <= UPDATE;
              end else begin
                state  <= IDLE;
                done_q <= 1'b1;
              end
            end
          end
        end
        UPDATE: begin
          scan_reg_q     <= sr;
          update_pulse_q <= 1'b1;
          done_q         <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.scan_out     = sr[NUM_SCAN_BITS-1 -: NUM_LANES];
  assign bus.scan_reg     = scan_reg_q;
  assign bus.done         = done_q;
  assign bus.update_pulse = update_pulse_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: a 16-bit single-lane chain and a
// 16-bit four-lane chain share clock and reset; expected values are
// hand-computed constants.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.NUM_SCAN_BITS(16), .NUM_LANES(1)) if1 ();
  scan_chain_ctrl_if #(.NUM_SCAN_BITS(16), .NUM_LANES(4)) if4 ();

  scan_chain_ctrl #(.NUM_SCAN_BITS(16), .NUM_LANES(1), .SCAN_RESET(16'h0000))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  scan_chain_ctrl #(.NUM_SCAN_BITS(16), .NUM_LANES(4), .SCAN_RESET(16'h0000))
    dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture pin, shift in sin MSB-first on the single-lane chain, update.
  // stall_mask bit c drops scan_in_valid on shift-phase cycle c.
  task automatic run_op11(input logic [15:0] pin, input logic [15:0] sin,
                          input logic [31:0] stall_mask, input int nst);
    int e;
    int s;
    int c;
    check("op11_ready", 32'(if1.cmd_ready), 32'd1);
    if1.cmd_valid = 1'b1;
    if1.cmd_op = 2'b11;
    if1.par_in = pin;
    if1.scan_in_valid = 1'b0;
    tick(); e = 0;
    if1.cmd_valid = 1'b0;
    tick(); e = 1;
    s = 0;
    c = 0;
    while (s < 16 && c < 32) begin
      if1.scan_in_valid = !stall_mask[c];
      if1.scan_in = sin[15-s];
      check("op11_scan_out", 32'(if1.scan_out), 32'(pin[15-s]));
      tick(); e++;
      if (!stall_mask[c]) s++;
      c++;
    end
    check("op11_shift_count", 32'(s), 32'd16);
    if1.scan_in_valid = 1'b0;
    check("op11_no_early_done", 32'(if1.done), 32'd0);
    tick(); e++;
    check("op11_done", 32'(if1.done), 32'd1);
    check("op11_update_pulse", 32'(if1.update_pulse), 32'd1);
    check("op11_scan_reg", 32'(if1.scan_reg), 32'(sin));
    check("op11_latency", 32'(e), 32'(18 + nst));
    tick();
    check("op11_done_one_cycle", 32'(if1.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    if1.cmd_valid = 1'b0; if1.cmd_op = 2'b00; if1.scan_in = '0;
    if1.scan_in_valid = 1'b0; if1.par_in = '0;
    if4.cmd_valid = 1'b0; if4.cmd_op = 2'b00; if4.scan_in = '0;
    if4.scan_in_valid = 1'b0; if4.par_in = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("init_scan_reg", 32'(if1.scan_reg), 32'h0);
    check("init_scan_out", 32'(if1.scan_out), 32'h0);
    check("init_ready", 32'(if1.cmd_ready), 32'd1);

    // Reset for two cycles while both chains are busy.
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b11; if1.par_in = 16'hFFFF;
    if4.cmd_valid = 1'b1; if4.cmd_op = 2'b00; if4.scan_in = 4'hF;
    if1.scan_in_valid = 1'b1; if4.scan_in_valid = 1'b1; if1.scan_in = 1'b1;
    tick();
    if1.cmd_valid = 1'b0; if4.cmd_valid = 1'b0;
    tick(); tick();
    check("traffic_busy", 32'(if1.busy), 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    if1.scan_in_valid = 1'b0; if4.scan_in_valid = 1'b0;
    check("rst_scan_reg", 32'(if1.scan_reg), 32'h0);
    check("rst_ready", 32'(if1.cmd_ready), 32'd1);
    check("rst_busy", 32'(if1.busy), 32'd0);
    check("rst_done", 32'(if1.done), 32'd0);
    check("rst_update", 32'(if1.update_pulse), 32'd0);
    check("rst4_busy", 32'(if4.busy), 32'd0);
    check("rst4_done", 32'(if4.done), 32'd0);

    // Full capture/shift/update without stalls.
    run_op11(16'hA5C3, 16'h1234, 32'h0, 0);

    // Same with five stalled cycles in the shift phase.
    run_op11(16'hA5C3, 16'h1234, 32'h0002_0832, 5);

    // Four-lane chain: plain shift of nibbles 1,2,3,4 then update.
    check("l4_ready", 32'(if4.cmd_ready), 32'd1);
    if4.cmd_valid = 1'b1; if4.cmd_op = 2'b00; if4.scan_in_valid = 1'b1;
    if4.scan_in = 4'h0;
    tick();
    if4.cmd_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if4.scan_in = 4'(n);
      tick();
      if (n == 3) check("l4_no_early_done", 32'(if4.done), 32'd0);
    end
    if4.scan_in_valid = 1'b0;
    check("l4_shift_done", 32'(if4.done), 32'd1);
    check("l4_shift_no_update", 32'(if4.update_pulse), 32'd0);
    check("l4_scan_reg_held", 32'(if4.scan_reg), 32'h0);
    check("l4_scan_out", 32'(if4.scan_out), 32'h1);
    check("l4_idle", 32'(if4.busy), 32'd0);
    if4.cmd_valid = 1'b1; if4.cmd_op = 2'b10;
    tick();
    if4.cmd_valid = 1'b0;
    check("l4_upd_pending", 32'(if4.update_pulse), 32'd0);
    tick();
    check("l4_upd_pulse", 32'(if4.update_pulse), 32'd1);
    check("l4_upd_done", 32'(if4.done), 32'd1);
    check("l4_upd_scan_reg", 32'(if4.scan_reg), 32'h1234);

    // Load BEEF, then reset with cnt=7 in a second op=11.
    run_op11(16'h0000, 16'hBEEF, 32'h0, 0);
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b11; if1.par_in = 16'h8001;
    tick();
    if1.cmd_valid = 1'b0;
    tick();
    if1.scan_in_valid = 1'b1; if1.scan_in = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("mid_scan_reg_held", 32'(if1.scan_reg), 32'hBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if1.scan_in_valid = 1'b0;
    check("mid_rst_scan_reg", 32'(if1.scan_reg), 32'h0);
    check("mid_rst_busy", 32'(if1.busy), 32'd0);
    check("mid_rst_scan_out", 32'(if1.scan_out), 32'h0);
    seen = 0;
    if1.scan_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (if1.done || if1.update_pulse) seen++;
      tick();
    end
    if1.scan_in_valid = 1'b0;
    check("mid_rst_no_done", 32'(seen), 32'd0);
    run_op11(16'hA5C3, 16'h1234, 32'h0, 0);

    // op=01 with cmd_valid held; the next command lands in the done cycle.
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b01; if1.par_in = 16'h5A0F;
    tick();
    if1.cmd_op = 2'b10;
    tick();
    if1.par_in = 16'hFFFF;
    if1.scan_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] cap;
      logic [15:0] sin;
      cap = 16'h5A0F;
      sin = 16'h0F0F;
      if1.scan_in = sin[15-i];
      check("b2b_scan_out", 32'(if1.scan_out), 32'(cap[15-i]));
      if (i == 5) check("b2b_not_ready", 32'(if1.cmd_ready), 32'd0);
      tick();
    end
    if1.scan_in_valid = 1'b0;
    check("b2b_done", 32'(if1.done), 32'd1);
    check("b2b_no_update", 32'(if1.update_pulse), 32'd0);
    check("b2b_ready_in_done", 32'(if1.cmd_ready), 32'd1);
    check("b2b_scan_reg_held", 32'(if1.scan_reg), 32'h1234);
    tick();
    if1.cmd_valid = 1'b0;
    check("b2b_second_accepted", 32'(if1.busy), 32'd1);
    check("b2b_done_cleared", 32'(if1.done), 32'd0);
    tick();
    check("b2b_upd_pulse", 32'(if1.update_pulse), 32'd1);
    check("b2b_upd_scan_reg", 32'(if1.scan_reg), 32'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Single-clock, parametrised scan chain that replaces the two-phase clk1/clk2 serial scan chain.
- Shifts NUM_LANES bits per cycle and has a command FSM that sequences capture, shift and update.
- Holds off shifting while the serial source stalls, and signals completion with a done pulse.
- Sits between the test-access pins and the crypto core. It drives configuration (message, addresses) through scan_reg and captures read-back data through par_in.

Parameters:
- NUM_SCAN_BITS, 395, total chain length; must be a multiple of NUM_LANES (elaboration error otherwise).
- NUM_LANES, 1, bits shifted per cycle (scan_in/scan_out width).
- SCAN_RESET, {NUM_SCAN_BITS{1'b0}}, reset value of scan_reg.
- Derived: SHIFT_CYCLES = NUM_SCAN_BITS/NUM_LANES; CW = $clog2(SHIFT_CYCLES)+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid&&cmd_ready.
- cmd_op  in  2  00=SHIFT, 01=CAPTURE+SHIFT, 10=UPDATE, 11=CAPTURE+SHIFT+UPDATE.
- scan_in  in  NUM_LANES  serial data, MSB of the chain word first.
- scan_in_valid  in  1  shift-enable; one shift step per cycle while high in SHIFT.
- scan_out  out  NUM_LANES  sr[NUM_SCAN_BITS-1 -: NUM_LANES], combinational from sr.
- busy  out  1  state != IDLE.
- par_in  in  NUM_SCAN_BITS  parallel capture data.
- scan_reg  out  NUM_SCAN_BITS  update (shadow) register driving the core.
- update_pulse  out  1  registered; one cycle high when scan_reg takes a new value.
- done  out  1  registered; one cycle high when a command completes.

Behaviour:
- Reset (rst=1 at a clock edge) applies from any state, mid-operation included:
  - state=IDLE, sr=0, cnt=0, scan_reg=SCAN_RESET, done=0, update_pulse=0.
  - An aborted command produces no done and no update.
- States: IDLE, CAPTURE, SHIFT, UPDATE.
- IDLE:
  - On accept, latch cmd_op.
  - 01/11 go to CAPTURE; 00 goes to SHIFT with cnt=0; 10 goes to UPDATE.
- CAPTURE (1 cycle): sr<=par_in; cnt<=0; go to SHIFT.
- SHIFT:
  - If scan_in_valid: sr<={sr[NUM_SCAN_BITS-NUM_LANES-1:0], scan_in}; cnt<=cnt+1.
  - If !scan_in_valid: sr and cnt hold (stall, no timeout).
  - Consumers sample scan_out on the same edge that scan_in is sampled.
  - On the shift with cnt==SHIFT_CYCLES-1:
    - op 11: go to UPDATE.
    - op 00/01: go to IDLE and set done<=1.
- UPDATE (1 cycle): scan_reg<=sr; update_pulse<=1; done<=1; go to IDLE.
- Bit mapping: the first NUM_LANES bits shifted in end up at the MSBs of scan_reg.
- Latency (acceptance edge = edge 0):
  - op 11: done=update_pulse=1 after edge SHIFT_CYCLES+2, with no stalls.
  - op 00: done after edge SHIFT_CYCLES.
  - op 01: done after edge SHIFT_CYCLES+1.
  - op 10: done after edge 1.
- done/update_pulse are high during the first IDLE cycle, so a new command may be accepted in that same cycle (back-to-back allowed).
- cmd_valid while busy is ignored (not queued); cmd_op changes after acceptance have no effect.
- scan_reg changes only in UPDATE or on reset; SHIFT never disturbs the core configuration.
- scan_out is undefined-but-stable outside SHIFT (it reflects sr); after reset it is 0.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic -> scan_reg=SCAN_RESET, cmd_ready=1, busy=0, done=0, update_pulse=0.
- NUM_SCAN_BITS=16, NUM_LANES=1, op=11, par_in=16'hA5C3, scan_in=16'h1234 MSB-first, valid held high:
  - scan_out emits bits of A5C3 MSB-first.
  - done=update_pulse=1 after edge 18; scan_reg=16'h1234.
- NUM_SCAN_BITS=16, NUM_LANES=4:
  - op=00 with nibbles 1,2,3,4 -> done after edge 4, scan_reg unchanged.
  - Then op=10 -> scan_reg=16'h1234 and update_pulse after 1 edge.
- Stall: same as the op=11 case with scan_in_valid low on 5 random cycles -> identical scan_reg/scan_out sequence, done delayed by exactly 5 cycles.
- Reset mid-SHIFT (cnt=7) with a prior scan_reg=16'hBEEF -> scan_reg=SCAN_RESET, no done; a fresh op=11 then completes normally.
- Busy/back-to-back: cmd_valid held during an op=01 -> second command accepted only in the done cycle; op=01 result on scan_out equals the par_in value sampled at the CAPTURE cycle.
